// File: rtl/interrupt_cpu_debug_pkg.sv
// Shared types and jdo field positions for the debug-memory engine.
package interrupt_cpu_debug_pkg;

  localparam int DEBUG_DATA_W = 32;
  localparam int JDO_W        = 38;

  localparam int JDO_WDATA_LO = 3;
  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_ADDR_LO  = 26;
  localparam int JDO_ADDR_HI  = 33;
  localparam int JDO_CLR_OVR  = 35;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JRD,
    ST_JCAP,
    ST_JWR,
    ST_CRD,
    ST_CDONE,
    ST_CWR
  } state_e;

  // One captured JTAG request; ld marks an address-loading read.
  typedef struct packed {
    logic                    wr;
    logic                    ld;
    logic [7:0]              addr;
    logic [DEBUG_DATA_W-1:0] wdata;
  } jreq_t;

endpackage

// File: rtl/interrupt_cpu_debug_ram.sv
// Single-port debug RAM with byte enables.
// Latency: 1-cycle synchronous read; read-during-write returns old data.
// Backpressure: none, accepts an access every cycle.
module interrupt_cpu_debug_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    q <= mem[addr];
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/interrupt_cpu_debug_mem_engine.sv
// JTAG/CPU arbitrated access engine for the private debug RAM.
// Latency: JTAG read 3 clocks, JTAG write 2; CPU read 2 wait cycles, CPU write 1.
// Backpressure: one-deep JTAG slot drops extra strobes (sticky overrun); CPU held via waitrequest.
module interrupt_cpu_debug_mem_engine
  import interrupt_cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              mon_busy,
  output logic              mon_overrun,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest
);

  state_e              state, state_nxt;
  jreq_t               in_req, pend, sel_req;
  logic                pend_vld;
  logic                strobe_any, strobe_multi, ovr_set, jreq_vld;
  logic [ADDR_W-1:0]   jaddr;
  logic [DATA_W-1:0]   jwdata, rdata_q, ram_q, ram_wdata;
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we;
  logic [3:0]          ram_be;
  logic                unused_jdo;

  assign unused_jdo = &{1'b0, jdo[JDO_W-1:JDO_CLR_OVR+1]};

  assign strobe_any   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign strobe_multi = (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_no_action_ocimem_a & take_action_ocimem_b);
  assign ovr_set      = strobe_multi | (strobe_any & pend_vld);
  assign jreq_vld     = pend_vld | strobe_any;
  assign sel_req      = pend_vld ? pend : in_req;

  always_comb begin
    in_req       = '0;
    in_req.wr    = ~take_action_ocimem_a & ~take_no_action_ocimem_a;
    in_req.ld    = take_action_ocimem_a;
    in_req.addr  = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
    in_req.wdata = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    cpu_waitrequest = 1'b1;
    ram_addr        = jaddr;
    ram_we          = 1'b0;
    ram_be          = 4'hF;
    ram_wdata       = jwdata;
    unique case (state)
      ST_IDLE: begin
        if (jreq_vld)       state_nxt = sel_req.wr ? ST_JWR : ST_JRD;
        else if (cpu_read)  state_nxt = ST_CRD;
        else if (cpu_write) state_nxt = ST_CWR;
      end
      ST_JRD:  state_nxt = ST_JCAP;
      ST_JCAP: state_nxt = ST_IDLE;
      ST_JWR: begin
        ram_we    = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_CRD: begin
        ram_addr  = cpu_address;
        state_nxt = ST_CDONE;
      end
      ST_CDONE: begin
        cpu_waitrequest = 1'b0;
        state_nxt       = ST_IDLE;
      end
      ST_CWR: begin
        cpu_waitrequest = 1'b0;
        ram_addr        = cpu_address;
        ram_we          = 1'b1;
        ram_be          = cpu_byteenable;
        ram_wdata       = cpu_writedata;
        state_nxt       = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld    <= 1'b0;
      pend        <= '0;
      jaddr       <= '0;
      jwdata      <= '0;
      MonDReg     <= '0;
      rdata_q     <= '0;
      mon_overrun <= 1'b0;
    end else begin
      // Address load is deferred to dispatch so it never races a post-increment.
      if (state == ST_IDLE && jreq_vld) begin
        if (sel_req.ld) jaddr <= sel_req.addr[ADDR_W-1:0];
        jwdata <= sel_req.wdata;
      end
      if (state == ST_JCAP || state == ST_JWR) jaddr <= jaddr + ADDR_W'(1);
      if (state == ST_JCAP)  MonDReg <= ram_q;
      if (state == ST_CDONE) rdata_q <= ram_q;

      if (state == ST_IDLE && pend_vld) begin
        pend_vld <= 1'b0;
      end else if (!pend_vld && strobe_any && state != ST_IDLE) begin
        pend_vld <= 1'b1;
        pend     <= in_req;
      end

      if (take_action_ocimem_a && jdo[JDO_CLR_OVR]) mon_overrun <= 1'b0;
      else if (ovr_set)                              mon_overrun <= 1'b1;
    end
  end

  assign mon_busy     = pend_vld | (state == ST_JRD) | (state == ST_JCAP) | (state == ST_JWR);
  assign cpu_readdata = (state == ST_CDONE) ? ram_q : rdata_q;

  interrupt_cpu_debug_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_interrupt_cpu_debug_mem_engine.sv
// Directed bench for the debug-memory engine: JTAG path, CPU path, arbitration, overrun, reset.
module tb_interrupt_cpu_debug_mem_engine;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0]       MonDReg;
  logic              mon_busy, mon_overrun;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read, cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  interrupt_cpu_debug_mem_engine #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .mon_busy                (mon_busy),
    .mon_overrun             (mon_overrun),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the chosen strobes for exactly one edge.
  task automatic jtag(input logic a, input logic na, input logic b,
                      input logic [7:0] addr, input logic [31:0] data, input logic clr);
    jdo = '0;
    jdo[34:3] = data;
    if (a) jdo[33:26] = addr;
    jdo[35] = clr;
    take_action_ocimem_a    = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b    = b;
    tick();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic cpu_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output int waits);
    cpu_address    = addr;
    cpu_writedata  = wdata;
    cpu_byteenable = be;
    cpu_read       = ~wr;
    cpu_write      = wr;
    waits = 0;
    while (cpu_waitrequest && waits < 50) begin
      tick();
      waits++;
    end
    rdata = cpu_readdata;
    tick();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          waits;

    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    cpu_byteenable = '0;
    repeat (3) tick();
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_readdata", cpu_readdata, 32'h0);
    check("rst_waitreq", 32'(cpu_waitrequest), 32'd1);
    check("rst_busy", 32'(mon_busy), 32'd0);
    check("rst_overrun", 32'(mon_overrun), 32'd0);
    reset_n = 1'b1;
    tick();

    // JTAG write at 0, then address-loading read of 0 with 3-clock latency
    jtag(1'b0, 1'b0, 1'b1, 8'h00, 32'hDEADBEEF, 1'b0);
    check("jwr_busy", 32'(mon_busy), 32'd1);
    tick();
    check("jwr_done_busy", 32'(mon_busy), 32'd0);
    jtag(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    check("jrd_e1", MonDReg, 32'h0);
    tick();
    check("jrd_e2", MonDReg, 32'h0);
    tick();
    check("jrd_e3", MonDReg, 32'hDEADBEEF);

    // jaddr is 1 after the read; a bare write must land at address 1
    jtag(1'b0, 1'b0, 1'b1, 8'h00, 32'h12345678, 1'b0);
    tick();
    cpu_xfer(1'b0, 8'h01, 32'h0, 4'hF, rd, waits);
    check("jaddr_post_inc", rd, 32'h12345678);

    // address wrap from 0xFF to 0
    jtag(1'b1, 1'b0, 1'b0, 8'hFE, 32'h0, 1'b0);
    tick(); tick();
    jtag(1'b0, 1'b0, 1'b1, 8'h00, 32'hCAFEF00D, 1'b0);
    tick();
    jtag(1'b1, 1'b0, 1'b0, 8'hFF, 32'h0, 1'b0);
    tick(); tick();
    check("rd_ff", MonDReg, 32'hCAFEF00D);
    jtag(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
    tick(); tick();
    check("wrap_rd_0", MonDReg, 32'hDEADBEEF);

    // CPU byte-enabled write and read-back
    cpu_xfer(1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, rd, waits);
    check("cwr_waits", 32'(waits), 32'd1);
    cpu_xfer(1'b1, 8'h05, 32'h11223344, 4'b0101, rd, waits);
    check("cwr_be_waits", 32'(waits), 32'd1);
    cpu_xfer(1'b0, 8'h05, 32'h0, 4'hF, rd, waits);
    check("crd_data", rd, 32'hFF22FF44);
    check("crd_waits", 32'(waits), 32'd2);

    // JTAG read (address 1) and CPU read in the same cycle: JTAG first
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    cpu_address = 8'h05;
    cpu_read = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    check("arb_jtag_busy", 32'(mon_busy), 32'd1);
    waits = 1;
    while (cpu_waitrequest && waits < 50) begin
      tick();
      waits++;
    end
    check("arb_waits", 32'(waits), 32'd5);
    check("arb_cpu_data", cpu_readdata, 32'hFF22FF44);
    check("arb_jtag_data", MonDReg, 32'h12345678);
    tick();
    cpu_read = 1'b0;

    // three consecutive strobes overrun the one-deep slot
    jtag(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
    jtag(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
    check("ovr_after_two", 32'(mon_overrun), 32'd0);
    check("slot_busy", 32'(mon_busy), 32'd1);
    jtag(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
    check("ovr_after_three", 32'(mon_overrun), 32'd1);
    repeat (3) tick();
    check("slot_drained", 32'(mon_busy), 32'd0);
    check("ovr_sticky", 32'(mon_overrun), 32'd1);
    jtag(1'b1, 1'b0, 1'b0, 8'h05, 32'h0, 1'b1);
    check("ovr_clear", 32'(mon_overrun), 32'd0);
    tick(); tick();
    check("jtag_sees_cpu", MonDReg, 32'hFF22FF44);

    // simultaneous strobes: loser is dropped; clear beats a same-cycle set
    jtag(1'b1, 1'b0, 1'b1, 8'h05, 32'h0, 1'b0);
    check("ovr_simul", 32'(mon_overrun), 32'd1);
    tick(); tick();
    jtag(1'b1, 1'b0, 1'b1, 8'h00, 32'h0, 1'b1);
    check("clr_priority", 32'(mon_overrun), 32'd0);

    // reset during JCAP
    tick();
    check("pre_rst_mondreg", MonDReg, 32'hFF22FF44);
    reset_n = 1'b0;
    #2;
    check("midrst_mondreg", MonDReg, 32'h0);
    check("midrst_busy", 32'(mon_busy), 32'd0);
    check("midrst_waitreq", 32'(cpu_waitrequest), 32'd1);
    reset_n = 1'b1;
    tick();
    cpu_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd, waits);
    check("ram_kept_0", rd, 32'hDEADBEEF);
    check("post_rst_waits", 32'(waits), 32'd2);
    jtag(1'b1, 1'b0, 1'b0, 8'hFF, 32'h0, 1'b0);
    tick(); tick();
    check("ram_kept_ff", MonDReg, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
